// File: rtl/ib_pipe_if.sv
// Internal bus word channel: data plus active-low framing and handshake.
interface ib_pipe_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] data;
  logic                  sop_n;
  logic                  eop_n;
  logic                  src_rdy_n;
  logic                  dst_rdy_n;

  // Source side of the channel.
  modport master (
    output data,
    output sop_n,
    output eop_n,
    output src_rdy_n,
    input  dst_rdy_n
  );

  // Sink side of the channel.
  modport slave (
    input  data,
    input  sop_n,
    input  eop_n,
    input  src_rdy_n,
    output dst_rdy_n
  );
endinterface

// File: rtl/ib_pipe.sv
// Two-slot (main + skid) register pipe for the internal bus. Fully registered in both
// directions: outputs come straight from the main slot and the upstream ready is a flop,
// so no combinational path crosses the stage.
module ib_pipe #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  ib_pipe_if.slave    in_i,
  ib_pipe_if.master   out_o
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic                  main_sop_n_q, main_sop_n_d;
  logic                  main_eop_n_q, main_eop_n_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_sop_n_q, skid_sop_n_d;
  logic                  skid_eop_n_q, skid_eop_n_d;
  logic                  in_rdy_n_q;

  logic in_xfer;
  logic out_xfer;
  logic out_vld;

  assign out_vld  = (state_q != StEmpty);
  assign in_xfer  = ~in_i.src_rdy_n & ~in_rdy_n_q;
  assign out_xfer = out_vld & ~out_o.dst_rdy_n;

  // Next-state and slot-load decisions.
  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_sop_n_d = main_sop_n_q;
    main_eop_n_d = main_eop_n_q;
    skid_data_d  = skid_data_q;
    skid_sop_n_d = skid_sop_n_q;
    skid_eop_n_d = skid_eop_n_q;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          main_data_d  = in_i.data;
          main_sop_n_d = in_i.sop_n;
          main_eop_n_d = in_i.eop_n;
          state_d      = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          // Main drains and refills in the same cycle.
          main_data_d  = in_i.data;
          main_sop_n_d = in_i.sop_n;
          main_eop_n_d = in_i.eop_n;
        end else if (in_xfer) begin
          skid_data_d  = in_i.data;
          skid_sop_n_d = in_i.sop_n;
          skid_eop_n_d = in_i.eop_n;
          state_d      = StFull;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // Upstream ready is deasserted here, so only the output side can move.
        if (out_xfer) begin
          main_data_d  = skid_data_q;
          main_sop_n_d = skid_sop_n_q;
          main_eop_n_d = skid_eop_n_q;
          state_d      = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // State, slots and registered upstream ready; reset discards both slots.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StEmpty;
      main_data_q  <= '0;
      main_sop_n_q <= 1'b1;
      main_eop_n_q <= 1'b1;
      skid_data_q  <= '0;
      skid_sop_n_q <= 1'b1;
      skid_eop_n_q <= 1'b1;
      in_rdy_n_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_sop_n_q <= main_sop_n_d;
      main_eop_n_q <= main_eop_n_d;
      skid_data_q  <= skid_data_d;
      skid_sop_n_q <= skid_sop_n_d;
      skid_eop_n_q <= skid_eop_n_d;
      in_rdy_n_q   <= (state_d == StFull);
    end
  end

  assign in_i.dst_rdy_n  = in_rdy_n_q;
  assign out_o.data      = main_data_q;
  assign out_o.sop_n     = main_sop_n_q;
  assign out_o.eop_n     = main_eop_n_q;
  assign out_o.src_rdy_n = ~out_vld;

endmodule

// File: tb/tb_ib_pipe.sv
// Self-checking bench for ib_pipe: directed scenarios plus a randomized scoreboard run.
module tb_ib_pipe;
  localparam int unsigned DW = 64;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } word_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  ib_pipe_if #(.DATA_WIDTH(DW)) in_bus ();
  ib_pipe_if #(.DATA_WIDTH(DW)) out_bus ();

  ib_pipe #(.DATA_WIDTH(DW)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .in_i    (in_bus),
    .out_o   (out_bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic s, input logic e);
    in_bus.src_rdy_n = ~v;
    in_bus.data      = d;
    in_bus.sop_n     = s;
    in_bus.eop_n     = e;
  endtask

  task automatic idle();
    drive(1'b0, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 64'hdead_beef_0000_0001, 1'b0, 1'b0);
    out_bus.dst_rdy_n = 1'b1;
    step();
    step();
    total++; if (out_bus.src_rdy_n !== 1'b1) begin bad++;
      $display("FAIL reset_out_vld: got %b want 1", out_bus.src_rdy_n); end
    total++; if (in_bus.dst_rdy_n !== 1'b1) begin bad++;
      $display("FAIL reset_in_rdy: got %b want 1", in_bus.dst_rdy_n); end
    total++; if ({out_bus.sop_n, out_bus.eop_n} !== 2'b11) begin bad++;
      $display("FAIL reset_sop_eop: got %b%b want 11", out_bus.sop_n, out_bus.eop_n); end
    total++; if (out_bus.data !== '0) begin bad++;
      $display("FAIL reset_data: got %h want 0", out_bus.data); end
    reset = 1'b0;
    idle();
    step();
    total++; if (in_bus.dst_rdy_n !== 1'b0) begin bad++;
      $display("FAIL post_reset_in_rdy: got %b want 0", in_bus.dst_rdy_n); end
    total++; if (out_bus.src_rdy_n !== 1'b1) begin bad++;
      $display("FAIL post_reset_out_vld: got %b want 1", out_bus.src_rdy_n); end
  endtask

  task automatic test_single();
    out_bus.dst_rdy_n = 1'b0;
    drive(1'b1, 64'h1122334455667788, 1'b0, 1'b0);
    step();
    idle();
    total++; if (out_bus.src_rdy_n !== 1'b0) begin bad++;
      $display("FAIL single_vld: got %b want 0", out_bus.src_rdy_n); end
    total++; if ({out_bus.data, out_bus.sop_n, out_bus.eop_n} !== {64'h1122334455667788, 2'b00})
      begin bad++;
      $display("FAIL single_word: got %h %b%b want 1122334455667788 00",
               out_bus.data, out_bus.sop_n, out_bus.eop_n); end
    step();
    total++; if (out_bus.src_rdy_n !== 1'b1) begin bad++;
      $display("FAIL single_one_cycle: got %b want 1", out_bus.src_rdy_n); end
  endtask

  task automatic test_back_to_back();
    out_bus.dst_rdy_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, DW'(i), (i != 0), (i != 15));
      step();
      total++;
      if ({out_bus.src_rdy_n, out_bus.data, out_bus.sop_n, out_bus.eop_n} !==
          {1'b0, DW'(i), (i != 0), (i != 15)}) begin bad++;
        $display("FAIL stream_word%0d: got v=%b %h %b%b want v=0 %h %b%b", i, out_bus.src_rdy_n,
                 out_bus.data, out_bus.sop_n, out_bus.eop_n, DW'(i), (i != 0), (i != 15)); end
      total++; if (in_bus.dst_rdy_n !== 1'b0) begin bad++;
        $display("FAIL stream_in_rdy%0d: got %b want 0", i, in_bus.dst_rdy_n); end
    end
    idle();
    step();
    total++; if (out_bus.src_rdy_n !== 1'b1) begin bad++;
      $display("FAIL stream_end: got %b want 1", out_bus.src_rdy_n); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a = 64'haaaa_0000_0000_000a;
    logic [DW-1:0] b = 64'hbbbb_0000_0000_000b;
    logic [DW-1:0] c = 64'hcccc_0000_0000_000c;
    out_bus.dst_rdy_n = 1'b1;
    drive(1'b1, a, 1'b0, 1'b1);
    step();
    total++; if (in_bus.dst_rdy_n !== 1'b0 || out_bus.data !== a) begin bad++;
      $display("FAIL bp_a: got rdy=%b %h want rdy=0 %h", in_bus.dst_rdy_n, out_bus.data, a); end
    drive(1'b1, b, 1'b1, 1'b1);
    step();
    total++; if (in_bus.dst_rdy_n !== 1'b1) begin bad++;
      $display("FAIL bp_full_rdy: got %b want 1", in_bus.dst_rdy_n); end
    drive(1'b1, c, 1'b1, 1'b0);
    step();
    step();
    total++; if ({out_bus.src_rdy_n, in_bus.dst_rdy_n, out_bus.data, out_bus.sop_n} !==
                 {1'b0, 1'b1, a, 1'b0}) begin bad++;
      $display("FAIL bp_hold: got v=%b rdy=%b %h want v=0 rdy=1 %h",
               out_bus.src_rdy_n, in_bus.dst_rdy_n, out_bus.data, a); end
    out_bus.dst_rdy_n = 1'b0;
    step();
    total++; if ({out_bus.src_rdy_n, out_bus.data} !== {1'b0, b}) begin bad++;
      $display("FAIL bp_b: got v=%b %h want v=0 %h", out_bus.src_rdy_n, out_bus.data, b); end
    total++; if (in_bus.dst_rdy_n !== 1'b0) begin bad++;
      $display("FAIL bp_reopen: got %b want 0", in_bus.dst_rdy_n); end
    step();
    idle();
    total++; if ({out_bus.src_rdy_n, out_bus.data, out_bus.eop_n} !== {1'b0, c, 1'b0}) begin
      bad++;
      $display("FAIL bp_c: got v=%b %h want v=0 %h", out_bus.src_rdy_n, out_bus.data, c); end
    step();
    total++; if (out_bus.src_rdy_n !== 1'b1) begin bad++;
      $display("FAIL bp_drain: got %b want 1", out_bus.src_rdy_n); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] w;
    out_bus.dst_rdy_n = 1'b0;
    drive(1'b1, 64'h5000, 1'b0, 1'b1);
    step();
    for (int i = 1; i <= 8; i++) begin
      w = 64'h5000 + DW'(i);
      drive(1'b1, w, 1'b1, (i != 8));
      step();
      total++;
      if ({out_bus.src_rdy_n, in_bus.dst_rdy_n, out_bus.data} !== {1'b0, 1'b0, w}) begin bad++;
        $display("FAIL simul%0d: got v=%b rdy=%b %h want v=0 rdy=0 %h", i, out_bus.src_rdy_n,
                 in_bus.dst_rdy_n, out_bus.data, w); end
    end
    idle();
    step();
    total++; if (out_bus.src_rdy_n !== 1'b1) begin bad++;
      $display("FAIL simul_drain: got %b want 1", out_bus.src_rdy_n); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] z = 64'h2222_3333_4444_5555;
    out_bus.dst_rdy_n = 1'b1;
    drive(1'b1, 64'hffff_0000_0000_0001, 1'b0, 1'b1);
    step();
    drive(1'b1, 64'hffff_0000_0000_0002, 1'b1, 1'b1);
    step();
    idle();
    total++; if (in_bus.dst_rdy_n !== 1'b1) begin bad++;
      $display("FAIL rmid_full: got %b want 1", in_bus.dst_rdy_n); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_bus.dst_rdy_n = 1'b0;
    total++; if ({out_bus.src_rdy_n, out_bus.data} !== {1'b1, DW'(0)}) begin bad++;
      $display("FAIL rmid_clear: got v=%b %h want v=1 0", out_bus.src_rdy_n, out_bus.data); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_bus.src_rdy_n !== 1'b1) begin bad++;
        $display("FAIL rmid_ghost%0d: got %b want 1", i, out_bus.src_rdy_n); end
    end
    drive(1'b1, z, 1'b0, 1'b0);
    step();
    idle();
    total++; if ({out_bus.src_rdy_n, out_bus.data} !== {1'b0, z}) begin bad++;
      $display("FAIL rmid_z: got v=%b %h want v=0 %h", out_bus.src_rdy_n, out_bus.data, z); end
    step();
    total++; if (out_bus.src_rdy_n !== 1'b1) begin bad++;
      $display("FAIL rmid_z_drain: got %b want 1", out_bus.src_rdy_n); end
  endtask

  task automatic test_random();
    word_t exp_q[$];
    word_t cur;
    word_t obs;
    word_t prev_obs;
    bit    have_cur = 1'b0;
    bit    malformed = 1'b0;
    bit    prev_hold = 1'b0;
    bit    src_v;
    bit    dst_n;
    bit    in_x;
    bit    out_x;
    int    pkts = 0;
    int    idx = 0;
    int    len = 1;
    int    cycles = 0;
    while ((pkts < 1000 || have_cur || exp_q.size() != 0) && cycles < 90000) begin
      obs = '{d: out_bus.data, s: out_bus.sop_n, e: out_bus.eop_n};
      total++; if (out_bus.src_rdy_n !== (exp_q.size() == 0)) begin bad++;
        if (bad < 20) $display("FAIL rnd_out_vld: got %b want %b (cycle %0d)",
                               out_bus.src_rdy_n, (exp_q.size() == 0), cycles); end
      total++; if (in_bus.dst_rdy_n !== (exp_q.size() == 2)) begin bad++;
        if (bad < 20) $display("FAIL rnd_in_rdy: got %b want %b (cycle %0d)",
                               in_bus.dst_rdy_n, (exp_q.size() == 2), cycles); end
      if (out_bus.src_rdy_n == 1'b0 && exp_q.size() > 0) begin
        total++; if (obs !== exp_q[0]) begin bad++;
          if (bad < 20) $display("FAIL rnd_word: got %h %b%b want %h %b%b (cycle %0d)",
                                 obs.d, obs.s, obs.e, exp_q[0].d, exp_q[0].s, exp_q[0].e,
                                 cycles); end
      end
      if (prev_hold) begin
        total++; if (obs !== prev_obs) begin bad++;
          if (bad < 20) $display("FAIL rnd_stable: got %h want %h (cycle %0d)",
                                 obs, prev_obs, cycles); end
      end
      if (!have_cur && pkts < 1000) begin
        if (idx == 0) begin
          len = $urandom_range(1, 32);
          malformed = ($urandom_range(0, 7) == 0);
        end
        cur.d = {$urandom, $urandom};
        cur.s = malformed ? 1'($urandom_range(0, 1)) : (idx != 0);
        cur.e = malformed ? 1'($urandom_range(0, 1)) : (idx != len - 1);
        idx++;
        if (idx == len) begin
          idx = 0;
          pkts++;
        end
        have_cur = 1'b1;
      end
      src_v = have_cur && ($urandom_range(0, 1) == 1);
      if (src_v) drive(1'b1, cur.d, cur.s, cur.e);
      else idle();
      dst_n = 1'($urandom_range(0, 1));
      out_bus.dst_rdy_n = dst_n;
      in_x      = src_v && (in_bus.dst_rdy_n == 1'b0);
      out_x     = (out_bus.src_rdy_n == 1'b0) && !dst_n;
      prev_hold = (out_bus.src_rdy_n == 1'b0) && dst_n;
      prev_obs  = obs;
      if (out_x && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_x) begin
        exp_q.push_back(cur);
        have_cur = 1'b0;
      end
      step();
      cycles++;
    end
    total++; if (cycles >= 90000) begin bad++;
      $display("FAIL rnd_timeout: got %0d cycles want < 90000", cycles); end
    total++; if (exp_q.size() != 0) begin bad++;
      $display("FAIL rnd_leftover: got %0d words want 0", exp_q.size()); end
    idle();
    out_bus.dst_rdy_n = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/ib_pipe.md
IB_PIPE -- requirements
Module: ib_pipe

Interface
REQ-001 Generic DATA_WIDTH, default 64, width of internal bus data word (legal: 8, 16, 32, 64, 128).
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RESET  in  1  reset is synchronous and active-high.
REQ-004 IN_DATA  in  DATA_WIDTH  upstream data word (from ib_transformer DOWN_TX side).
REQ-005 IN_SOP_N  in  1  start of packet, active low.
REQ-006 IN_EOP_N  in  1  end of packet, active low.
REQ-007 IN_SRC_RDY_N  in  1  upstream word valid, active low.
REQ-008 IN_DST_RDY_N  out  1  pipe can accept word, active low.
REQ-009 OUT_DATA  out  DATA_WIDTH  downstream data word.
REQ-010 OUT_SOP_N  out  1  start of packet, active low.
REQ-011 OUT_EOP_N  out  1  end of packet, active low.
REQ-012 OUT_SRC_RDY_N  out  1  downstream word valid, active low.
REQ-013 OUT_DST_RDY_N  in  1  downstream can accept, active low.

Function
REQ-014 Input transfer SHALL occur in a cycle where IN_SRC_RDY_N=0 and IN_DST_RDY_N=0; output transfer where OUT_SRC_RDY_N=0 and OUT_DST_RDY_N=0.
REQ-015 Storage SHALL be two word slots (MAIN, SKID), each holding DATA, SOP_N, EOP_N.
REQ-016 FSM SHALL have states EMPTY, ONE (MAIN valid), FULL (MAIN and SKID valid).
REQ-017 EMPTY: input transfer -> word into MAIN, go ONE.
REQ-018 ONE: input only -> word into SKID, go FULL; output only -> go EMPTY; input and output same cycle -> word into MAIN, stay ONE.
REQ-019 FULL: output transfer -> SKID moves into MAIN, go ONE; no input accepted in FULL.
REQ-020 IN_DST_RDY_N SHALL be a register output, 0 iff next state is not FULL.
REQ-021 OUT_DATA/OUT_SOP_N/OUT_EOP_N SHALL be driven directly from MAIN register; OUT_SRC_RDY_N=0 iff state is ONE or FULL.
REQ-022 Latency SHALL be exactly 1 cycle from input transfer into empty pipe to OUT_SRC_RDY_N=0.
REQ-023 Sustained throughput SHALL be one word per cycle when OUT_DST_RDY_N held 0.
REQ-024 Word order and SOP/EOP markings SHALL be preserved exactly; no word dropped or duplicated.
REQ-025 Pipe SHALL NOT check packet framing; malformed SOP/EOP sequences pass unchanged.
REQ-026 OUT_DATA/SOP/EOP SHALL remain stable while OUT_SRC_RDY_N=0 and OUT_DST_RDY_N=1.
REQ-027 IN_DATA/SOP/EOP SHALL be ignored when IN_SRC_RDY_N=1 or IN_DST_RDY_N=1.
REQ-028 No combinational path SHALL exist from OUT_DST_RDY_N to IN_DST_RDY_N or from IN_* to OUT_*.

Reset
REQ-029 RESET=1 at a rising edge SHALL force state EMPTY, OUT_SRC_RDY_N=1, IN_DST_RDY_N=1, OUT_SOP_N=1, OUT_EOP_N=1, OUT_DATA=0.
REQ-030 Cycle after RESET deasserts, IN_DST_RDY_N SHALL be 0.
REQ-031 RESET mid-packet SHALL discard both slots; no partial word emitted afterwards.

Verification
REQ-032 Single word: IN_DATA=0x1122334455667788, SOP_N=EOP_N=0 for one cycle, OUT_DST_RDY_N=0 -> same word on OUT next cycle, OUT_SRC_RDY_N=0 for exactly one cycle.
REQ-033 Streaming: 16-word packet (data 0..15) back-to-back, OUT_DST_RDY_N=0 -> output 0..15 on 16 consecutive cycles, SOP_N=0 on word 0, EOP_N=0 on word 15.
REQ-034 Backpressure: OUT_DST_RDY_N=1 while sending words A,B,C -> A,B stored, IN_DST_RDY_N=1 from cycle after B accepted, C held by source; release -> output A,B,C in order, no gaps after first.
REQ-035 Simultaneous: state ONE, input and output transfer same cycle for 8 cycles -> state stays ONE, IN_DST_RDY_N stays 0, order preserved.
REQ-036 Reset mid-operation: state FULL with words X,Y, assert RESET one cycle -> OUT_SRC_RDY_N=1, OUT_DATA=0, X,Y never appear; next word Z passes with 1-cycle latency.
REQ-037 Random: random SRC_RDY/DST_RDY toggling (50%), 1000 packets of 1-32 words, scoreboard -> output stream identical to input stream, REQ-026 holds every cycle.
